// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes decoded by the core's control unit, loader
// request kinds, loader state encoding and the field-to-word encoder.
package mips_pkg;

   localparam logic [5:0] R_TYPE = 6'h00;
   localparam logic [5:0] ADDI   = 6'h08;
   localparam logic [5:0] ORI    = 6'h0d;
   localparam logic [5:0] ANDI   = 6'h0c;
   localparam logic [5:0] LUI    = 6'h0f;

   localparam logic [2:0] KIND_R    = 3'd0;
   localparam logic [2:0] KIND_ADDI = 3'd1;
   localparam logic [2:0] KIND_ORI  = 3'd2;
   localparam logic [2:0] KIND_ANDI = 3'd3;
   localparam logic [2:0] KIND_LUI  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } loadState_t;

   function automatic logic isLegalKind(input logic [2:0] kind);
      return kind <= KIND_LUI;
   endfunction

   function automatic logic [31:0] encode_instr(
      input logic [2:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm
   );
      logic [31:0] word;
      case (kind)
         KIND_R:    word = {R_TYPE, rs, rt, rd, shamt, funct};
         KIND_ADDI: word = {ADDI, rs, rt, imm};
         KIND_ORI:  word = {ORI, rs, rt, imm};
         KIND_ANDI: word = {ANDI, rs, rt, imm};
         // LUI has no source register; the rs slot is architecturally zero
         KIND_LUI:  word = {LUI, 5'd0, rt, imm};
         default:   word = 32'h0000_0000;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous request FIFO with flush; push is ignored while full and pop
// while empty, so callers may request freely.
module instr_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W:0]   wrPtr;
   logic [PTR_W:0]   rdPtr;
   logic             doPush;
   logic             doPop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                   (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign rdData = store[rdPtr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (PTR_W+1)'(1);
         if (doPop)  rdPtr <= rdPtr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) store[wrPtr[PTR_W-1:0]] <= wrData;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field-level requests into MIPS words, buffers them
// and writes them sequentially into the instruction memory write port.
module instr_encoder_loader
   import mips_pkg::*;
#(
   parameter int MEM_DEPTH  = 64,
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_shamt,
   input  logic [5:0]        req_funct,
   input  logic [15:0]       req_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              overflow,
   output logic [ADDR_W:0]   words_written
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   loadState_t        state;
   loadState_t        nextState;
   logic [ADDR_W-1:0] wrPtr;
   logic              memExhausted;
   logic              active;
   logic              reqAccept;
   logic              legalKind;
   logic              overflowHit;
   logic              fifoPush;
   logic              fifoPop;
   logic              fifoFlush;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [31:0]       encWord_p0;
   logic [31:0]       fifoHead;

   assign active      = (state == ST_LOAD) || (state == ST_DRAIN);
   assign busy        = active;
   assign done        = (state == ST_DONE);
   assign req_ready   = (state == ST_LOAD) && !fifoFull && !memExhausted;
   assign reqAccept   = req_valid && req_ready;
   assign legalKind   = isLegalKind(req_kind);
   assign encWord_p0  = encode_instr(req_kind, req_rs, req_rt, req_rd,
                                     req_shamt, req_funct, req_imm);

   // Memory is full but work is still queued or being offered: abandon it
   assign overflowHit = !start && active && memExhausted &&
                        (!fifoEmpty || ((state == ST_LOAD) && req_valid));

   // Illegal kinds complete the handshake but never enter the FIFO
   assign fifoPush    = reqAccept && legalKind && !start;
   assign fifoPop     = active && !fifoEmpty && !memExhausted && !start;
   assign fifoFlush   = start || overflowHit;

   instr_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (fifoFlush),
      .push   (fifoPush),
      .wrData (encWord_p0),
      .pop    (fifoPop),
      .rdData (fifoHead),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      if (start) begin
         nextState = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (overflowHit)  nextState = ST_DONE;
               else if (finish)  nextState = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (overflowHit || fifoEmpty) nextState = ST_DONE;
            end
            default: nextState = state;
         endcase
      end
   end

   // Write stage: a pop registers one memory write and advances the pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr         <= '0;
         memExhausted  <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         error         <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else if (start) begin
         wrPtr         <= base_addr;
         memExhausted  <= 1'b0;
         mem_we        <= 1'b0;
         error         <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else begin
         mem_we <= fifoPop;
         if (fifoPop) begin
            mem_addr      <= wrPtr;
            mem_wdata     <= fifoHead;
            words_written <= words_written + (ADDR_W+1)'(1);
            // Pointer parks on the last word instead of wrapping
            if (wrPtr == LAST_ADDR) memExhausted <= 1'b1;
            else                    wrPtr        <= wrPtr + ADDR_W'(1);
         end
         if (reqAccept && !legalKind) error    <= 1'b1;
         if (overflowHit)             overflow <= 1'b1;
      end
   end

endmodule
